mdu_seq: RTL and testbench
==========================

// Module: mdu_seq
// PURPOSE
//   Iterative multiply/divide unit with HI/LO registers for the single-cycle CPU.
//   The datapath issues MULT/MULTU/DIV/DIVU with a start pulse, stalls on busy and
//   reads HI/LO once the unit returns done. MTHI/MTLO write HI/LO directly.
//   Responder side of a start/busy/done handshake; the core is the initiator.
// PARAMETERS
//   WIDTH    32   operand width; the product and the {rem,quot} pair are 2*WIDTH
// PORTS
//   clk      in   1        rising-edge clock
//   rstn     in   1        asynchronous reset, active-low
//   start    in   1        request; sampled only in IDLE or DONE
//   op       in   2        00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A        in   WIDTH    multiplicand / dividend (rs)
//   B        in   WIDTH    multiplier / divisor (rt)
//   hi_we    in   1        MTHI write enable
//   lo_we    in   1        MTLO write enable
//   wdata    in   WIDTH    MTHI/MTLO data
//   busy     out  1        operation in flight; core must stall MDU-dependent instrs
//   done     out  1        one-cycle pulse; HI/LO hold the new result in this cycle
//   hi       out  WIDTH    HI register (product high / remainder)
//   lo       out  WIDTH    LO register (product low / quotient)
// BEHAVIOUR
//   Reset (rstn=0, async): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//   States:
//     IDLE -start-> CALC
//     CALC (WIDTH cycles) -> FIX
//     FIX (1 cycle) -> DONE
//     DONE (1 cycle) -start-> CALC, else -> IDLE
//   Accept (IDLE/DONE with start=1): latch op, |A|, |B| (magnitudes for signed ops,
//     raw for unsigned), result sign flags; clear the accumulator; counter=0.
//   CALC, MULT: radix-2 shift-add, one multiplier bit per cycle, 2*WIDTH accumulator.
//   CALC, DIV: restoring division, one quotient bit per cycle; WIDTH+1-bit trial subtract.
//   FIX: negate the product if the operand signs differ (signed MULT only).
//     DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
//     Write hi/lo at the end of FIX.
//   Timing: busy=1 for exactly WIDTH+1 cycles (CALC+FIX), starting the cycle after accept.
//     done=1 for exactly one cycle, WIDTH+1 edges after the accepting edge.
//     busy=0 in DONE.
//   Back-to-back: start during DONE is accepted; done and the new busy do not overlap.
//   start while busy is ignored, not queued. op/A/B are don't-care outside accept.
//   Divide by zero (B=0): full latency regardless.
//     Result: LO=all ones, HI=A (unsigned)/A (signed); no trap.
//   Signed overflow (DIV, A=0x80000000, B=-1): LO=0x80000000, HI=0.
//   hi_we/lo_we: write wdata at the edge, only in IDLE or DONE; ignored while busy.
//     start and hi_we/lo_we in the same accepting cycle: start wins, write dropped.
//   Reset mid-operation aborts immediately: the partial result is lost and no done pulse follows.
//   hi/lo change only on reset, MTHI/MTLO, or the end of FIX.
// TESTING
//   MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> done after 33 edges; HI=0xFFFFFFFE, LO=0x00000001
//   MULT A=-3 B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles
//   DIV A=-7 B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU A=7 B=0 -> LO=0xFFFFFFFF, HI=7
//   DIV A=0x80000000 B=0xFFFFFFFF -> LO=0x80000000, HI=0; start pulsed at cycle 5 of CALC ignored
//   Back-to-back: start in the DONE cycle with MULTU 3*5 -> second done 33 edges later, HI=0, LO=15
//   rstn low at CALC cycle 10 -> busy=0, hi=lo=0, no done; MTLO 0x1234 while busy ignored, in IDLE LO=0x1234

Source files
------------

// File: rtl/mdu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mdu_seq : iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Rev 1.0
// ---------------------------------------------------------------------------
module mdu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state, state_nx;
  logic               accept, open_win, last;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_lo, neg_hi;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;

  logic               a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] mul_next, div_next, prod;
  logic [WIDTH-1:0]   quot, rem;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_CALC;
      S_CALC:  if (last)  state_nx = S_FIX;
      S_FIX:   state_nx = S_DONE;
      default: state_nx = start ? S_CALC : S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == S_CALC) || (state == S_FIX);
    done     = (state == S_DONE);
    open_win = (state == S_IDLE) || (state == S_DONE);
    accept   = open_win && start;
  end

  assign last = (cnt == CW'(WIDTH-1));

  // Signed ops work on magnitudes; signs are restored in FIX.
  assign a_neg  = ~op[0] & A[WIDTH-1];
  assign b_neg  = ~op[0] & B[WIDTH-1];
  assign b_zero = (B == '0);
  assign a_mag  = a_neg ? -A : A;
  assign b_mag  = b_neg ? -B : B;

  // Multiply: multiplier sits in acc low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
  assign trial    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign prod = neg_lo ? -acc : acc;
  assign quot = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem  = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      acc    <= '0;
      opnd   <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op[1];
      // Divide by zero keeps the all-ones quotient unsigned-looking.
      neg_lo <= (a_neg ^ b_neg) & ~(op[1] & b_zero);
      neg_hi <= a_neg;
      acc    <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      opnd   <= op[1] ? b_mag : a_mag;
    end else if (state == S_CALC) begin
      cnt <= cnt + 1'b1;
      acc <= is_div ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hi <= '0;
      lo <= '0;
    end else if (state == S_FIX) begin
      hi <= is_div ? rem  : prod[2*WIDTH-1:WIDTH];
      lo <= is_div ? quot : prod[WIDTH-1:0];
    end else if (open_win && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_mdu_seq : directed + randomized bench for mdu_seq against an arithmetic model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] A = '0, B = '0, wdata = '0;
  logic        hi_we = 1'b0, lo_we = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  mdu_seq #(.WIDTH(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {hi, lo} from plain arithmetic on the operands.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'd0: begin q = sa * sb; res = q; end
      2'd1: begin uq = ua * ub; res = uq; end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'd2) begin
          q = sa / sb; r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          uq = ua / ub; ur = ua % ub;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Caller is at a negedge. Returns at the negedge of the done cycle when chain=1.
  task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                    input bit with_mtlo, input bit chain);
    logic [63:0] r;
    int e, busy_n;
    r = model(o, a, b);
    op = o; A = a; B = b; start = 1'b1;
    if (with_mtlo) begin lo_we = 1'b1; wdata = $urandom; end
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); A = $urandom; B = $urandom;
    busy_n = 0;
    for (e = 0; e < 45; e++) begin
      @(negedge clk);
      if (e == 3) chk("hold_hilo", {hi, lo}, {exp_hi, exp_lo});
      if (e == 5) begin start = 1'b1; op = 2'($urandom); A = $urandom; B = $urandom; end
      if (e == 6) start = 1'b0;
      if (e == 7) begin lo_we = 1'b1; wdata = 32'h1234; end
      if (e == 8) lo_we = 1'b0;
      if (done) break;
      if (busy) busy_n++;
    end
    chk("done_latency", 64'(e), 64'd33);
    chk("busy_cycles", 64'(busy_n), 64'd33);
    chk("busy_in_done", {63'd0, busy}, 64'd0);
    chk("result", {hi, lo}, r);
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    if (!chain) begin
      @(negedge clk);
      chk("done_pulse", {63'd0, done}, 64'd0);
    end
  endtask

  task automatic mt(input bit to_hi, input logic [31:0] d);
    hi_we = to_hi; lo_we = ~to_hi; wdata = d;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (to_hi) begin exp_hi = d; chk("mthi", {32'd0, hi}, {32'd0, d}); end
    else       begin exp_lo = d; chk("mtlo", {32'd0, lo}, {32'd0, d}); end
    @(negedge clk);
  endtask

  initial begin
    bit seen;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    bit          rc;

    #12;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);

    mt(1'b1, 32'hCAFE_F00D);
    mt(1'b0, 32'h0000_1234);

    go(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    go(2'd0, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    go(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    go(2'd3, 32'd7, 32'd0, 1'b0, 1'b0);
    chk("divu_zero", {hi, lo}, 64'h0000_0007_FFFF_FFFF);
    go(2'd2, 32'hFFFF_FFF9, 32'd0, 1'b0, 1'b0);
    chk("div_zero_neg", {hi, lo}, 64'hFFFF_FFF9_FFFF_FFFF);
    go(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);

    go(2'd3, 32'd100, 32'd7, 1'b0, 1'b1);
    go(2'd1, 32'd3, 32'd5, 1'b0, 1'b0);
    chk("b2b_multu", {hi, lo}, 64'h0000_0000_0000_000F);

    go(2'd0, 32'd9, 32'hFFFF_FFF7, 1'b1, 1'b0);

    // Abort mid-calculation with reset.
    op = 2'd2; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(negedge clk);
    rstn = 1'b0; #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    exp_hi = '0; exp_lo = '0;
    @(negedge clk); rstn = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", {63'd0, seen}, 64'd0);
    mt(1'b0, 32'h0000_1234);

    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 15));
        default: ;
      endcase
      rc = (i != 29) && ($urandom_range(0, 3) == 0);
      go(ro, ra, rb, bit'($urandom_range(0, 1)), rc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
